t2mi_stream_parser: RTL and testbench

T2MI_STREAM_PARSER -- requirements
Module: t2mi_stream_parser

---
 rtl/t2mi_stream_parser.sv | 173 +++++++++++++++++
 tb/tb_t2mi_stream_parser.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t2mi_stream_parser.sv
// T2-MI byte-stream parser: hunts for the sync byte, decodes a type byte and
// a 16-bit payload length, forwards (or drops, when filtered) the payload on a
// registered valid/ready output, and tracks sync lock and error statistics.
//
// Handshake: a byte moves on either side only in a cycle where valid and ready
// are both high at the rising edge. Valid never waits on ready, and while
// out_valid=1 and out_ready=0 the payload output (valid, data, start, end) is
// held unchanged.
module t2mi_stream_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'h47,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 2,
  parameter int         MIN_LEN      = 4,
  parameter int         MAX_LEN      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        filter_en,
  input  logic [7:0]  filter_type,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_start,
  output logic        out_end,
  input  logic        out_ready,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_length,
  output logic        sync_locked,
  output logic        parser_error,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_TYPE    = 3'd1;
  localparam logic [2:0] S_LEN_HI  = 3'd2;
  localparam logic [2:0] S_LEN_LO  = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;

  localparam logic [7:0]  LOCK_C   = 8'(LOCK_COUNT);
  localparam logic [7:0]  UNLOCK_C = 8'(UNLOCK_COUNT);
  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);

  logic [2:0]  state;
  logic [7:0]  hdr_type;
  logic [7:0]  len_hi;
  logic [15:0] hdr_len;
  logic [15:0] byte_cnt;
  logic [7:0]  good_cnt;
  logic [7:0]  miss_cnt;
  logic        expect_sync;

  logic        in_xfer;
  logic [15:0] len_word;
  logic        len_ok;
  logic        last_byte;

  // Input is only throttled when a payload byte would overwrite a stalled output.
  assign in_ready  = (state != S_PAYLOAD) || !out_valid || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign len_word  = {len_hi, in_data};
  assign len_ok    = (len_word >= MIN_L) && (len_word <= MAX_L);
  assign last_byte = (byte_cnt == hdr_len - 16'd1);
  assign fsm_state = state;

  // Header FSM, packet/error statistics and sync-tracking counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_HUNT;
      hdr_type     <= 8'h00;
      len_hi       <= 8'h00;
      hdr_len      <= 16'h0000;
      byte_cnt     <= 16'h0000;
      pkt_type     <= 8'h00;
      pkt_length   <= 16'h0000;
      pkt_count    <= 16'h0000;
      err_count    <= 8'h00;
      good_cnt     <= 8'h00;
      miss_cnt     <= 8'h00;
      expect_sync  <= 1'b0;
      parser_error <= 1'b0;
    end else begin
      parser_error <= 1'b0;
      if (in_xfer) begin
        case (state)
          S_HUNT: begin
            // Only the first byte after a completed packet judges sync health.
            if (expect_sync) begin
              expect_sync <= 1'b0;
              if (in_data == SYNC_BYTE) begin
                miss_cnt <= 8'h00;
              end else begin
                good_cnt <= 8'h00;
                if (miss_cnt != UNLOCK_C) miss_cnt <= miss_cnt + 8'd1;
              end
            end
            if (in_data == SYNC_BYTE) state <= S_TYPE;
          end
          S_TYPE: begin
            hdr_type <= in_data;
            state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            hdr_len  <= len_word;
            byte_cnt <= 16'h0000;
            if (!len_ok) begin
              parser_error <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              good_cnt <= 8'h00;
              state    <= S_HUNT;
            end else if (filter_en && (hdr_type != filter_type)) begin
              state <= S_DROP;
            end else begin
              state      <= S_PAYLOAD;
              pkt_type   <= hdr_type;
              pkt_length <= len_word;
            end
          end
          S_PAYLOAD, S_DROP: begin
            byte_cnt <= byte_cnt + 16'd1;
            if (last_byte) begin
              state       <= S_HUNT;
              pkt_count   <= pkt_count + 16'd1;
              expect_sync <= 1'b1;
              if (good_cnt != LOCK_C) good_cnt <= good_cnt + 8'd1;
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

  // Registered payload output stage; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_start <= 1'b0;
      out_end   <= 1'b0;
    end else if (in_xfer && (state == S_PAYLOAD)) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_start <= (byte_cnt == 16'h0000);
      out_end   <= last_byte;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
    end
  end

  // Lock flag follows the good/miss counters one cycle later; losing sync wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_locked <= 1'b0;
    end else if (miss_cnt == UNLOCK_C) begin
      sync_locked <= 1'b0;
    end else if (good_cnt == LOCK_C) begin
      sync_locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t2mi_stream_parser.sv
// Bench for t2mi_stream_parser: table of header/length/filter cases with
// hand-computed outcomes, plus sequences for lock/unlock, random backpressure
// and reset in the middle of a packet. Payload bytes are checked through an
// expected queue of {start, end, data}.
module tb_t2mi_stream_parser;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        filter_en;
  logic [7:0]  filter_type;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_start;
  logic        out_end;
  logic        out_ready;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_length;
  logic        sync_locked;
  logic        parser_error;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;
  logic [2:0]  fsm_state;

  t2mi_stream_parser dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .filter_en    (filter_en),
    .filter_type  (filter_type),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_start    (out_start),
    .out_end      (out_end),
    .out_ready    (out_ready),
    .pkt_type     (pkt_type),
    .pkt_length   (pkt_length),
    .sync_locked  (sync_locked),
    .parser_error (parser_error),
    .pkt_count    (pkt_count),
    .err_count    (err_count),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;
  logic bp_mode = 1'b0;
  logic [9:0] exp_q[$];

  // model state
  int          m_pkt_count;
  int          m_err_count;
  logic [7:0]  m_type;
  logic [15:0] m_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic acc;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 1000);
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_timeout: byte %0h not accepted within 1000 cycles", b);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic send_header(input logic [7:0] typ, input logic [15:0] len);
    send_byte(8'h47);
    send_byte(typ);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  // Full legal packet; when fwd the payload is queued as expected output.
  task automatic send_packet(input logic [7:0] typ, input logic [15:0] len,
                             input logic [7:0] base, input logic fwd);
    if (fwd) begin
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back({(i == 0), (i == int'(len) - 1), 8'(int'(base) + i)});
    end
    send_header(typ, len);
    filter_type = ~filter_type;  // changes after the header must not matter
    for (int i = 0; i < int'(len); i++) send_byte(8'(int'(base) + i));
    m_pkt_count++;
    if (fwd) begin
      m_type = typ;
      m_len  = len;
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_pkt_count = 0;
    m_err_count = 0;
    m_type = 8'h00;
    m_len  = 16'h0000;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_start", 32'(out_start), 32'd0);
    chk("rst_out_end", 32'(out_end), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_parser_error", 32'(parser_error), 32'd0);
    chk("rst_sync_locked", 32'(sync_locked), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_pkt_type", 32'(pkt_type), 32'd0);
    chk("rst_pkt_length", 32'(pkt_length), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(m_pkt_count));
    chk({tag, "_err_count"}, 32'(err_count), 32'(m_err_count));
    chk({tag, "_pkt_type"}, 32'(pkt_type), 32'(m_type));
    chk({tag, "_pkt_length"}, 32'(pkt_length), 32'(m_len));
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic       have_prev = 1'b0;
  logic       prev_v, prev_r;
  logic [10:0] prev_word;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (parser_error) err_pulses++;
      if (have_prev && prev_v && !prev_r)
        chk("out_hold", 32'({out_valid, out_start, out_end, out_data}), 32'(prev_word));
      if (!out_valid)
        chk("start_end_without_valid", 32'({out_start, out_end}), 32'd0);
      if (!in_ready)
        chk("in_ready_low_only_when_stalled", 32'(out_valid && !out_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: data %0h start %0b end %0b", out_data, out_start, out_end);
        end else begin
          chk("out_byte", 32'({out_start, out_end, out_data}), 32'(exp_q.pop_front()));
        end
      end
      have_prev = 1'b1;
      prev_v    = out_valid;
      prev_r    = out_ready;
      prev_word = {out_valid, out_start, out_end, out_data};
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  typ;
    logic [15:0] len;
    logic        fen;
    logic [7:0]  ftype;
    logic        exp_fwd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses0;
    vecs[0] = '{8'h20, 16'h000C, 1'b0, 8'h00, 1'b1, 1'b0};  // basic 12-byte packet
    vecs[1] = '{8'h99, 16'h0002, 1'b0, 8'h00, 1'b0, 1'b1};  // too short
    vecs[2] = '{8'hA5, 16'h0004, 1'b0, 8'h00, 1'b1, 1'b0};  // MIN_LEN exactly
    vecs[3] = '{8'h11, 16'h0008, 1'b1, 8'h33, 1'b0, 1'b0};  // filtered out
    vecs[4] = '{8'h33, 16'h0008, 1'b1, 8'h33, 1'b1, 1'b0};  // filter match
    vecs[5] = '{8'h44, 16'h1001, 1'b0, 8'h00, 1'b0, 1'b1};  // MAX_LEN+1
    vecs[6] = '{8'h55, 16'h0003, 1'b0, 8'h00, 1'b0, 1'b1};  // MIN_LEN-1
    vecs[7] = '{8'h66, 16'h1000, 1'b1, 8'h66, 1'b1, 1'b0};  // MAX_LEN exactly

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    filter_en = 1'b0;
    filter_type = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pkt_count = 0;
    m_err_count = 0;
    m_type = 8'h00;
    m_len  = 16'h0000;
    check_reset_outputs();

    // table-driven header/length/filter cases
    for (int k = 0; k < 8; k++) begin
      filter_en   = vecs[k].fen;
      filter_type = vecs[k].ftype;
      pulses0 = err_pulses;
      if (vecs[k].exp_err) begin
        send_header(vecs[k].typ, vecs[k].len);
        m_err_count++;
      end else begin
        send_packet(vecs[k].typ, vecs[k].len, 8'(k * 16), vecs[k].exp_fwd);
      end
      idle(3);
      chk($sformatf("vec%0d_error_pulses", k), 32'(err_pulses - pulses0), 32'(vecs[k].exp_err));
      check_stats($sformatf("vec%0d", k));
    end
    filter_en = 1'b0;
    chk("table_queue_empty", 32'(exp_q.size()), 32'd0);

    // lock after three good packets, unlock after two missed syncs
    do_reset();
    send_packet(8'h01, 16'h0004, 8'h10, 1'b1);
    send_packet(8'h01, 16'h0004, 8'h20, 1'b1);
    chk("lock_not_yet", 32'(sync_locked), 32'd0);
    send_packet(8'h01, 16'h0004, 8'h30, 1'b1);
    chk("lock_third_out_end", 32'(out_end), 32'd1);
    chk("lock_still_low", 32'(sync_locked), 32'd0);
    idle(1);
    chk("lock_rises", 32'(sync_locked), 32'd1);
    send_byte(8'h00);
    send_packet(8'h02, 16'h0004, 8'h40, 1'b1);
    idle(1);
    chk("lock_after_one_miss", 32'(sync_locked), 32'd1);
    send_byte(8'h12);
    chk("lock_held_at_second_miss", 32'(sync_locked), 32'd1);
    idle(1);
    chk("lock_drops", 32'(sync_locked), 32'd0);
    send_packet(8'h02, 16'h0004, 8'h50, 1'b1);
    idle(2);
    chk("lock_stays_low", 32'(sync_locked), 32'd0);
    check_stats("lockseq");

    // 256-byte payload under random backpressure
    bp_mode = 1'b1;
    send_packet(8'h5A, 16'h0100, 8'h00, 1'b1);
    bp_mode = 1'b0;
    idle(4);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    check_stats("bp");

    // reset in the middle of a packet
    exp_q.push_back({1'b1, 1'b0, 8'hC0});
    for (int i = 1; i < 5; i++) exp_q.push_back({1'b0, 1'b0, 8'(8'hC0 + i)});
    send_header(8'h20, 16'h000A);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    idle(1);
    chk("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
    do_reset();
    check_reset_outputs();
    send_byte(8'hC5);
    send_byte(8'hC6);
    send_packet(8'h77, 16'h0006, 8'hE0, 1'b1);
    idle(3);
    chk("after_rst_queue_empty", 32'(exp_q.size()), 32'd0);
    check_stats("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
